// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan driver for a ROWS x COLS LED matrix with a multi-frame pixel buffer.
// Optional PWM dimming of the column lines is enabled by defining LED_SCAN_DIM_EN.
module led_matrix_scan_ctrl #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int FRAMES       = 2,
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYCLES = 4,
    parameter int FRAME_HOLD   = 1024,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int RW = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [FW-1:0]   wr_frame,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            anim_en,
    input  logic [FW-1:0]   frame_sel,
`ifdef LED_SCAN_DIM_EN
    input  logic [3:0]      bright,
`endif
    output logic [ROWS-1:0] vert,
    output logic [COLS-1:0] hori,
    output logic [FW-1:0]   cur_frame,
    output logic            frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    // With no blanking the next slot's row has to be fetched on the last prescaler count.
    localparam int SAMPLE_AT = (BLANK_CYCLES == 0) ? SCAN_DIV - 1 : BLANK_CYCLES - 1;
    localparam logic [ROWS-1:0] TOP_BIT = {1'b1, {(ROWS-1){1'b0}}};

    logic [COLS-1:0]        mem [FRAMES][ROWS];
    logic [FRAMES*ROWS-1:0] wr_hit;

    logic [PW-1:0]   presc_reg, presc_next;
    logic [RW-1:0]   row_reg, row_next;
    logic [HW-1:0]   hold_reg, hold_next;
    logic [FW-1:0]   frame_reg, frame_next;
    logic [COLS-1:0] row_data_reg;
    logic [ROWS-1:0] vert_reg;
    logic [COLS-1:0] hori_reg;
    logic            fs_reg;
    logic            tick, wrap, blank, gate;

    // Out-of-range write addresses match no entry, so they are dropped here.
    for (genvar gi = 0; gi < FRAMES; gi++) begin : g_frame
        for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
            assign wr_hit[gi*ROWS+gj] = wr_en && (wr_frame == FW'(gi)) && (wr_row == RW'(gj));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < FRAMES; f++)
                for (int r = 0; r < ROWS; r++)
                    mem[f][r] <= '0;
        end else begin
            for (int f = 0; f < FRAMES; f++)
                for (int r = 0; r < ROWS; r++)
                    if (wr_hit[f*ROWS+r]) mem[f][r] <= wr_data;
        end
    end

`ifdef LED_SCAN_DIM_EN
    logic [3:0] pwm_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt_reg <= '0;
        else        pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
    end
    assign gate = (pwm_cnt_reg > bright);
`else
    assign gate = 1'b0;
`endif

    always_comb begin
        tick       = (presc_reg == PW'(SCAN_DIV - 1));
        wrap       = tick && (row_reg == RW'(ROWS - 1));
        blank      = (32'(presc_reg) < BLANK_CYCLES);
        presc_next = tick ? '0 : presc_reg + 1'b1;
        row_next   = row_reg;
        hold_next  = hold_reg;
        frame_next = frame_reg;
        if (tick)
            row_next = (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + 1'b1;
        if (wrap) begin
            if (anim_en) begin
                if (hold_reg == HW'(FRAME_HOLD - 1)) begin
                    hold_next  = '0;
                    frame_next = (frame_reg == FW'(FRAMES - 1)) ? '0 : frame_reg + 1'b1;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end else begin
                hold_next  = '0;
                frame_next = (32'(frame_sel) < FRAMES) ? frame_sel : '0;
            end
        end
        if (FRAMES == 1) begin
            frame_next = '0;
            hold_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg    <= '0;
            row_reg      <= '0;
            hold_reg     <= '0;
            frame_reg    <= '0;
            row_data_reg <= '0;
            vert_reg     <= '1;
            hori_reg     <= '0;
            fs_reg       <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            row_reg   <= row_next;
            hold_reg  <= hold_next;
            frame_reg <= frame_next;
            // Latched once per slot so a rewrite of the visible row cannot tear it.
            if (presc_reg == PW'(SAMPLE_AT))
                row_data_reg <= mem[frame_next][row_next];
            vert_reg <= blank ? '1 : ~(TOP_BIT >> row_reg);
            hori_reg <= (blank || gate) ? '0 : row_data_reg;
            fs_reg   <= (presc_reg == PW'(BLANK_CYCLES)) && (row_reg == '0);
        end
    end

    assign vert        = vert_reg;
    assign hori        = hori_reg;
    assign cur_frame   = frame_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl: an 8x8/2-frame instance and a 6-row/3-frame
// instance for out-of-range frame addressing.
module tb_led_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_frame = '0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       anim_en = 1'b0;
    logic [0:0] frame_sel = '0;
    logic [7:0] vert, hori;
    logic [0:0] cur_frame;
    logic       frame_start;

    logic       w2_en = 1'b0;
    logic [1:0] w2_frame = '0;
    logic [2:0] w2_row = '0;
    logic [7:0] w2_data = '0;
    logic       anim2 = 1'b0;
    logic [1:0] sel2 = '0;
    logic [5:0] vert2;
    logic [7:0] hori2;
    logic [1:0] cur2;
    logic       fs2;

`ifdef LED_SCAN_DIM_EN
    logic [3:0] bright = 4'd15;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int fs_seen = 0;

    always #5 clk = ~clk;

    led_matrix_scan_ctrl #(
        .ROWS(8), .COLS(8), .FRAMES(2), .SCAN_DIV(16), .BLANK_CYCLES(2), .FRAME_HOLD(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row),
        .wr_data(wr_data), .anim_en(anim_en), .frame_sel(frame_sel),
`ifdef LED_SCAN_DIM_EN
        .bright(bright),
`endif
        .vert(vert), .hori(hori), .cur_frame(cur_frame), .frame_start(frame_start)
    );

    led_matrix_scan_ctrl #(
        .ROWS(6), .COLS(8), .FRAMES(3), .SCAN_DIV(8), .BLANK_CYCLES(2), .FRAME_HOLD(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(w2_en), .wr_frame(w2_frame), .wr_row(w2_row),
        .wr_data(w2_data), .anim_en(anim2), .frame_sel(sel2),
`ifdef LED_SCAN_DIM_EN
        .bright(bright),
`endif
        .vert(vert2), .hori(hori2), .cur_frame(cur2), .frame_start(fs2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        $display("vec %0d %s: got %0h expected %0h", n_vec, tag, obs, exp);
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_seen++;
        end
    endtask

    task automatic wait_fs(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 400);
        chk(tag, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_fs2(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fs2 !== 1'b1 && k < 400);
        chk(tag, 32'(fs2), 32'd1);
    endtask

    task automatic wr1(input logic [0:0] f, input logic [2:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_frame = f; wr_row = r; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] f, input logic [2:0] r, input logic [7:0] d);
        w2_en = 1'b1; w2_frame = f; w2_row = r; w2_data = d;
        @(negedge clk);
        w2_en = 1'b0;
    endtask

    logic [7:0] pat [8];
    logic [7:0] rvert [8];
    logic [0:0] f_pre [4];
    logic [0:0] f_post [4];
    logic [7:0] h_row0 [4];

    initial begin
        pat    = '{8'h00, 8'h19, 8'h33, 8'hFC, 8'hFC, 8'h33, 8'h19, 8'h00};
        rvert  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        f_pre  = '{1'b0, 1'b0, 1'b1, 1'b1};
        f_post = '{1'b0, 1'b1, 1'b1, 1'b0};
        h_row0 = '{8'h00, 8'h10, 8'h10, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_vert", 32'(vert), 32'hFF);
        chk("reset_hori", 32'(hori), 32'h00);
        chk("reset_frame", 32'(cur_frame), 32'd0);
        chk("reset_fs", 32'(frame_start), 32'd0);

        rst_n = 1'b1;
        wait_fs("first_fs");
        chk("first_vert", 32'(vert), 32'h7F);
        chk("first_hori", 32'(hori), 32'h00);

        for (int r = 0; r < 8; r++) wr1(1'b0, 3'(r), pat[r]);
        wait_fs("fill_fs");
        for (int r = 0; r < 8; r++) begin
            chk("scan_fs", 32'(frame_start), (r == 0) ? 32'd1 : 32'd0);
            chk("scan_vert", 32'(vert), 32'(rvert[r]));
            chk("scan_hori", 32'(hori), 32'(pat[r]));
            step(14);
            chk("blank_vert", 32'(vert), 32'hFF);
            chk("blank_hori", 32'(hori), 32'h00);
            step(2);
        end

        // Now at a frame_start; enable animation, next wrap is the first one counted.
        anim_en = 1'b1;
        wr1(1'b1, 3'd0, 8'h10);
        for (int i = 0; i < 4; i++) begin
            fs_seen = 0;
            step((i == 0) ? 123 : 124);
            chk("frame_pre_wrap", 32'(cur_frame), 32'(f_pre[i]));
            step(1);
            chk("frame_post_wrap", 32'(cur_frame), 32'(f_post[i]));
            step(3);
            chk("anim_fs", 32'(frame_start), 32'd1);
            chk("fs_per_scan", 32'(fs_seen), 32'd1);
            chk("anim_hori", 32'(hori), 32'(h_row0[i]));
        end

        wr1(1'b0, 3'd0, 8'hAA);
        chk("midwrite_hold", 32'(hori), 32'h00);
        step(8);
        chk("midwrite_hold2", 32'(hori), 32'h00);
        chk("midwrite_vert", 32'(vert), 32'h7F);
        wait_fs("midwrite_fs");
        chk("midwrite_next", 32'(hori), 32'hAA);
        chk("midwrite_frame", 32'(cur_frame), 32'd0);

        wait_fs("to_frame1_fs");
        chk("frame1_cur", 32'(cur_frame), 32'd1);
        chk("frame1_hori", 32'(hori), 32'h10);
        step(5);
        chk("prerst_vert", 32'(vert), 32'h7F);
        chk("prerst_hori", 32'(hori), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("async_vert", 32'(vert), 32'hFF);
        chk("async_hori", 32'(hori), 32'h00);
        chk("async_frame", 32'(cur_frame), 32'd0);
        chk("async_fs", 32'(frame_start), 32'd0);
        anim_en = 1'b0;
        frame_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs("postrst_fs");
        chk("postrst_vert", 32'(vert), 32'h7F);
        chk("postrst_hori", 32'(hori), 32'h00);
        chk("postrst_frame", 32'(cur_frame), 32'd0);

        sel2 = 2'd3;
        wr2(2'd3, 3'd0, 8'h55);
        wait_fs2("oob_fs_a");
        wait_fs2("oob_fs_b");
        chk("sel_oob_frame", 32'(cur2), 32'd0);
        chk("wr_oob_hori", 32'(hori2), 32'h00);
        chk("oob_vert", 32'(vert2), 32'h1F);
        wr2(2'd2, 3'd0, 8'h3C);
        sel2 = 2'd2;
        wait_fs2("sel2_fs_a");
        wait_fs2("sel2_fs_b");
        chk("sel2_frame", 32'(cur2), 32'd2);
        chk("sel2_hori", 32'(hori2), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
